alu_writeback_stage: RTL

- Execute/writeback stage consuming the control unit's decoded R-type outputs (`alu_control`, `regwrite_control`).
- Holds the 32x32 integer register file and performs the selected ALU operation on rs1/rs2.
- Registers the result for one cycle, then commits it to rd.
- Includes one-stage forwarding, a seed/load port and a retire counter for bring-up and verification.

---
 rtl/alu_writeback_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: 32-entry register file, R-type ALU, one-cycle result
// register with distance-1 forwarding, a seed-write port and a retire counter.
module alu_writeback_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [3:0]      alu_control,
   input  logic            regwrite_control,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic            ld_en,
   input  logic [4:0]      ld_addr,
   input  logic [XLEN-1:0] ld_data,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] result_out,
   output logic            illegal,
   output logic [31:0]     retired
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9
   } alu_op_e;

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] opa, opb, alu_res;
   logic [SHW-1:0]  shamt;
   logic            op_illegal;

   // x0 wins over forwarding; wb_valid already implies wb_rd != 0.
   always_comb begin
      opa = '0;
      opb = '0;
      if (rs1 != '0) opa = (wb_valid && wb_rd == rs1) ? result_out : regs[rs1];
      if (rs2 != '0) opb = (wb_valid && wb_rd == rs2) ? result_out : regs[rs2];
   end

   assign shamt    = opb[SHW-1:0];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

   always_comb begin
      alu_res    = '0;
      op_illegal = 1'b0;
      case (alu_control)
         OP_ADD:  alu_res = opa + opb;
         OP_SUB:  alu_res = opa - opb;
         OP_SLL:  alu_res = opa << shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
         OP_XOR:  alu_res = opa ^ opb;
         OP_SRL:  alu_res = opa >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
         OP_OR:   alu_res = opa | opb;
         OP_AND:  alu_res = opa & opb;
         default: op_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         result_out <= '0;
         wb_rd      <= '0;
         wb_valid   <= 1'b0;
         illegal    <= 1'b0;
         retired    <= '0;
      end else begin
         // Commit is written after the seed so it wins a same-address conflict.
         if (ld_en && ld_addr != '0) regs[ld_addr] <= ld_data;
         if (wb_valid) regs[wb_rd] <= result_out;
         if (valid_in) begin
            result_out <= alu_res;
            wb_rd      <= rd;
            wb_valid   <= regwrite_control && !op_illegal && (rd != '0);
            illegal    <= op_illegal;
            retired    <= retired + 32'd1;
         end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
         end
      end
   end

endmodule
